// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU counter bank: register map helpers,
// CTRL bit positions, EVSEL width and the access handshake states.
package pmu_pkg;

  localparam int EVSEL_WIDTH = 8;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_RST = 1;
  localparam int CTRL_FRZ = 2;

  typedef enum logic {
    IDLE,
    ACK
  } hs_state_e;

  function automatic int ctrl_idx(input int c);
    return 2 * c;
  endfunction

  function automatic int ovf_idx(input int c);
    return 2 * c + 1;
  endfunction

  function automatic int irqen_idx(input int c);
    return 2 * c + 2;
  endfunction

endpackage

// File: rtl/synchronizer_2_stage.sv
// Two-flop synchroniser for a single level signal.
// Ports: clk, rst (sync, active-low), d (async in), q (synchronised out).
module synchronizer_2_stage (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pmu_counter_bank.sv
// Per-tile programmable event counters with overflow status, freeze and IRQ.
// Ports: counter_clk/rst, 4-phase req/ack register access, pmu_sig_i, ovf_irq_o.
module pmu_counter_bank
  import pmu_pkg::*;
#(
  parameter int TILE_COUNT       = 1,
  parameter int EVENT_COUNT      = 23,
  parameter int COUNTER_COUNT    = 8,
  parameter int COUNTER_WIDTH    = 48,
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_TILE_WIDTH  = 7,
  parameter int ADDR_REG_WIDTH   = 6,
  parameter int ADDR_ALIGN_WIDTH = 3
) (
  input  logic                        counter_clk,
  input  logic                        rst,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [ADDR_TILE_WIDTH+ADDR_REG_WIDTH+ADDR_ALIGN_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  output logic                        ack_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        err_o,
  input  logic [TILE_COUNT*EVENT_COUNT-1:0] pmu_sig_i,
  output logic [TILE_COUNT-1:0]       ovf_irq_o
);

  localparam int C  = COUNTER_COUNT;
  localparam int T  = TILE_COUNT;
  localparam int CW = COUNTER_WIDTH;
  localparam int AW = ADDR_TILE_WIDTH + ADDR_REG_WIDTH + ADDR_ALIGN_WIDTH;

  logic req_s;

  synchronizer_2_stage u_req_sync (
    .clk (counter_clk),
    .rst (rst),
    .d   (req_i),
    .q   (req_s)
  );

  hs_state_e state_q, state_d;
  logic                  ack_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic [ADDR_TILE_WIDTH-1:0] a_tile;
  logic [ADDR_REG_WIDTH-1:0]  a_reg;
  logic tile_ok, reg_ok, acc, wr;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [CW-1:0]          cnt_q   [T][C];
  logic [CW-1:0]          cnt_d   [T][C];
  logic [EVSEL_WIDTH-1:0] evsel_q [T][C];
  logic [EVSEL_WIDTH-1:0] evsel_d [T][C];
  logic [C-1:0] ovf_q [T];
  logic [C-1:0] ovf_d [T];
  logic [C-1:0] irqen_q [T];
  logic [C-1:0] irqen_d [T];
  logic [C-1:0] hit [T];
  logic [C-1:0] wrap [T];
  logic [T-1:0] en_q, en_d, frz_q, frz_d;
  logic [T-1:0] wsel, ctrl_w, crst;

  logic unused_bits;
  assign unused_bits = ^{addr_i[ADDR_ALIGN_WIDTH-1:0], wdata_i};

  assign a_tile  = addr_i[AW-1 -: ADDR_TILE_WIDTH];
  assign a_reg   = addr_i[ADDR_ALIGN_WIDTH +: ADDR_REG_WIDTH];
  assign tile_ok = 32'(a_tile) < T;
  assign reg_ok  = 32'(a_reg) <= irqen_idx(C);
  assign acc     = (state_q == IDLE) && req_s;
  assign wr      = acc && we_i && tile_ok && reg_ok;

  // Read snapshot from current state; out-of-range reads all-ones.
  always_comb begin
    rd_mux = '1;
    if (tile_ok && reg_ok) begin
      rd_mux = '0;
      for (int t = 0; t < T; t++) begin
        if (32'(a_tile) == t) begin
          for (int i = 0; i < C; i++) begin
            if (32'(a_reg) == i)
              rd_mux[CW-1:0] = cnt_q[t][i];
            if (32'(a_reg) == C + i)
              rd_mux[EVSEL_WIDTH-1:0] = evsel_q[t][i];
          end
          unique case (1'b1)
            32'(a_reg) == ctrl_idx(C): begin
              rd_mux[CTRL_EN]  = en_q[t];
              rd_mux[CTRL_FRZ] = frz_q[t];
            end
            32'(a_reg) == ovf_idx(C):
              rd_mux[C-1:0] = ovf_q[t];
            32'(a_reg) == irqen_idx(C):
              rd_mux[C-1:0] = irqen_q[t];
            default: ;
          endcase
        end
      end
    end
  end

  // Event select; out-of-range selectors never match.
  always_comb begin
    for (int t = 0; t < T; t++) begin
      hit[t] = '0;
      for (int i = 0; i < C; i++)
        for (int e = 0; e < EVENT_COUNT; e++)
          if (32'(evsel_q[t][i]) == e)
            hit[t][i] = pmu_sig_i[t*EVENT_COUNT+e];
    end
  end

  // Priority per counter: CTRL.reset, write, increment.
  always_comb begin
    wsel   = '0;
    ctrl_w = '0;
    crst   = '0;
    for (int t = 0; t < T; t++) begin
      cnt_d[t]   = cnt_q[t];
      evsel_d[t] = evsel_q[t];
      irqen_d[t] = irqen_q[t];
      ovf_d[t]   = ovf_q[t];
      wrap[t]    = '0;
      en_d[t]    = en_q[t];
      frz_d[t]   = frz_q[t];
      wsel[t]    = wr && (32'(a_tile) == t);
      ctrl_w[t]  = wsel[t] && (32'(a_reg) == ctrl_idx(C));
      crst[t]    = ctrl_w[t] && wdata_i[CTRL_RST];
      for (int i = 0; i < C; i++) begin
        if (crst[t]) begin
          cnt_d[t][i] = '0;
        end else if (wsel[t] && 32'(a_reg) == i) begin
          cnt_d[t][i] = wdata_i[CW-1:0];
        end else if (en_q[t] && hit[t][i]) begin
          cnt_d[t][i] = cnt_q[t][i] + CW'(1);
          wrap[t][i]  = &cnt_q[t][i];
        end
        if (wsel[t] && 32'(a_reg) == C + i)
          evsel_d[t][i] = wdata_i[EVSEL_WIDTH-1:0];
      end
      // A new overflow wins over a same-edge clear.
      if (wsel[t] && 32'(a_reg) == ovf_idx(C))
        ovf_d[t] = ovf_q[t] & ~wdata_i[C-1:0];
      ovf_d[t] = crst[t] ? '0 : (ovf_d[t] | wrap[t]);
      if (wsel[t] && 32'(a_reg) == irqen_idx(C))
        irqen_d[t] = wdata_i[C-1:0];
      if (ctrl_w[t]) begin
        en_d[t]  = wdata_i[CTRL_EN];
        frz_d[t] = wdata_i[CTRL_FRZ];
      end else if (frz_q[t] && |wrap[t]) begin
        en_d[t] = 1'b0;
      end
    end
  end

  always_ff @(posedge counter_clk) begin
    if (!rst) begin
      for (int t = 0; t < T; t++) begin
        for (int i = 0; i < C; i++) begin
          cnt_q[t][i]   <= '0;
          evsel_q[t][i] <= (i < EVENT_COUNT) ?
                           EVSEL_WIDTH'(i) : '1;
        end
        ovf_q[t]   <= '0;
        irqen_q[t] <= '0;
      end
      en_q      <= '1;
      frz_q     <= '0;
      ovf_irq_o <= '0;
    end else begin
      cnt_q   <= cnt_d;
      evsel_q <= evsel_d;
      ovf_q   <= ovf_d;
      irqen_q <= irqen_d;
      en_q    <= en_d;
      frz_q   <= frz_d;
      for (int t = 0; t < T; t++)
        ovf_irq_o[t] <= |(ovf_q[t] & irqen_q[t]);
    end
  end

  always_ff @(posedge counter_clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_o   <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_o   <= ack_d;
      rdata_o <= rdata_d;
      err_o   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_o;
    rdata_d = rdata_o;
    err_d   = err_o;
    unique case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = ACK;
          ack_d   = 1'b1;
          rdata_d = we_i ? '0 : rd_mux;
          err_d   = !(tile_ok && reg_ok);
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
